data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_pkg.sv | 28 ++
 rtl/data_sram_resp_fifo.sv | 88 ++++++++
 rtl/data_sram_responder.sv | 87 ++++++++
 tb/tb_data_sram_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: access size codes,
// response-entry layout and the alignment rule applied at acceptance.
package data_sram_responder_pkg;

  // Access size encodings carried on data_sram_size
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Response-entry field widths
  localparam int RESP_DATA_W  = 32;
  localparam int RESP_TIMER_W = 3;   // holds LATENCY-1 for LATENCY up to 7

  // One queued response: kind of access plus the read word captured at acceptance
  typedef struct packed {
    logic                   wr;
    logic [RESP_DATA_W-1:0] rdata;
  } resp_entry_t;

  // Half-words must be 2-byte aligned, words 4-byte aligned; bytes never misalign
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// In-order response queue with a countdown timer per slot. The head's
// readiness and data are computed from next-state and registered, so
// head_ready is high exactly in the cycle the head's timer reads 0 and the
// entry leaves the queue at the end of that cycle (pop is tied to head_ready).
module data_sram_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  resp_entry_t              push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_ready,
  output logic [RESP_DATA_W-1:0]   head_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [RESP_TIMER_W-1:0] TIMER_INIT = RESP_TIMER_W'(LATENCY - 1);

  logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [PW:0]             count_reg, count_next;
  logic [RESP_TIMER_W-1:0] timer_reg  [DEPTH];
  logic [RESP_TIMER_W-1:0] timer_next [DEPTH];
  resp_entry_t             entry_reg  [DEPTH];

  logic                    head_ready_reg, head_ready_next;
  logic [RESP_DATA_W-1:0]  head_rdata_reg, head_rdata_next;
  logic                    head_is_new;
  resp_entry_t             head_entry_next;

  // Freshly pushed slots load LATENCY-1; every other slot counts down and holds at 0
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_timer
      localparam logic [PW-1:0] SLOT = PW'(gi);
      assign timer_next[gi] = (push && (wr_ptr_reg == SLOT)) ? TIMER_INIT :
                              (timer_reg[gi] != '0)          ? timer_reg[gi] - 1'b1 :
                                                               '0;
    end
  endgenerate

  // Pointer/count next-state and the next head's readiness and data
  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // The slot being written this cycle is the next head only when nothing older remains
    head_is_new     = push && (wr_ptr_reg == rd_ptr_next);
    head_entry_next = head_is_new ? push_entry : entry_reg[rd_ptr_next];
    head_ready_next = (count_next != '0) && (timer_next[rd_ptr_next] == '0);
    head_rdata_next = (head_ready_next && !head_entry_next.wr) ? head_entry_next.rdata : '0;
  end

  // Queue state and registered head outputs; reset drops everything outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_ready_reg <= 1'b0;
      head_rdata_reg <= '0;
      for (int i = 0; i < DEPTH; i++) timer_reg[i] <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_ready_reg <= head_ready_next;
      head_rdata_reg <= head_rdata_next;
      for (int i = 0; i < DEPTH; i++) timer_reg[i] <= timer_next[i];
      if (push) entry_reg[wr_ptr_reg] <= push_entry;
    end
  end

  assign count      = count_reg;
  assign head_ready = head_ready_reg;
  assign head_rdata = head_rdata_reg;

endmodule

// File: rtl/data_sram_responder.sv
// On-chip data memory answering the CPU data-side SRAM-like interface:
// address-phase handshake, then one in-order data_ok pulse per accepted request.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int AW      = 12,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall_inject,
  output logic        misalign_err
);

  localparam int WORDS = 1 << AW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          accept;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  resp_entry_t   push_entry;
  logic          misalign_err_reg;
  logic          unused_addr_hi;

  // Acceptance ignores a same-cycle retire: a full queue reopens the cycle after it drains
  assign data_sram_addr_ok = !reset && data_sram_req && !stall_inject &&
                             (count < CW'(DEPTH));
  assign accept   = data_sram_req && data_sram_addr_ok;
  assign word_idx = data_sram_addr[AW+1:2];
  assign unused_addr_hi = &{1'b0, data_sram_addr[31:AW+2]};

  // One byte-wide array per lane so each strobe bit gates its own write port
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_lane
      logic [7:0] lane_mem [WORDS];

      // Commit the enabled byte at the edge ending the accepting cycle
      always_ff @(posedge clk) begin
        if (accept && data_sram_wr && data_sram_wstrb[gi])
          lane_mem[word_idx] <= data_sram_wdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Reads snapshot the word now, so later writes cannot leak into this response
  assign push_entry.wr    = data_sram_wr;
  assign push_entry.rdata = data_sram_wr ? '0 : rd_word;

  data_sram_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (data_sram_data_ok),
    .count      (count),
    .head_ready (data_sram_data_ok),
    .head_rdata (data_sram_rdata)
  );

  // Sticky misalignment flag; the offending request is still served
  always_ff @(posedge clk) begin
    if (reset)
      misalign_err_reg <= 1'b0;
    else if (accept && is_misaligned(data_sram_size, data_sram_addr[1:0]))
      misalign_err_reg <= 1'b1;
  end

  assign misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: instance A runs LATENCY=1, instance B runs LATENCY=3,
// both DEPTH=2. Inputs change 1 time unit after posedge; outputs are
// checked at the following negedge.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (LATENCY = 1)
  logic        a_reset, a_req, a_wr, a_stall;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_addr_ok, a_data_ok, a_mis;
  logic [31:0] a_rdata;

  // Instance B (LATENCY = 3)
  logic        b_reset, b_req, b_wr, b_stall;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_addr_ok, b_data_ok, b_mis;
  logic [31:0] b_rdata;

  data_sram_responder #(.AW(6), .LATENCY(1), .DEPTH(2)) u_dut_a (
    .clk(clk), .reset(a_reset),
    .data_sram_req(a_req), .data_sram_wr(a_wr), .data_sram_size(a_size),
    .data_sram_addr(a_addr), .data_sram_wstrb(a_wstrb), .data_sram_wdata(a_wdata),
    .data_sram_addr_ok(a_addr_ok), .data_sram_data_ok(a_data_ok),
    .data_sram_rdata(a_rdata), .stall_inject(a_stall), .misalign_err(a_mis)
  );

  data_sram_responder #(.AW(6), .LATENCY(3), .DEPTH(2)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .data_sram_req(b_req), .data_sram_wr(b_wr), .data_sram_size(b_size),
    .data_sram_addr(b_addr), .data_sram_wstrb(b_wstrb), .data_sram_wdata(b_wdata),
    .data_sram_addr_ok(b_addr_ok), .data_sram_data_ok(b_data_ok),
    .data_sram_rdata(b_rdata), .stall_inject(b_stall), .misalign_err(b_mis)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic a_drive(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    a_req = req; a_wr = wr; a_size = size; a_addr = addr; a_wstrb = strb; a_wdata = wd;
  endtask

  task automatic b_drive(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    b_req = req; b_wr = wr; b_size = size; b_addr = addr; b_wstrb = strb; b_wdata = wd;
  endtask

  // B: one full-word write, then idle until its response has come and gone
  task automatic b_write_word(input logic [31:0] addr, input logic [31:0] wd);
    $display("[B] write addr=%08h wdata=%08h", addr, wd);
    b_drive(1'b1, 1'b1, 2'd2, addr, 4'hF, wd);
    smp(); chk("b_wr_addr_ok", 32'(b_addr_ok), 32'd1);
    cyc(); b_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("b_wr_lat_t1", 32'(b_data_ok), 32'd0);
    cyc(); smp(); chk("b_wr_lat_t2", 32'(b_data_ok), 32'd0);
    cyc(); smp(); chk("b_wr_data_ok", 32'(b_data_ok), 32'd1);
    chk("b_wr_rdata_zero", b_rdata, 32'h0);
    cyc(); smp(); chk("b_wr_pulse_end", 32'(b_data_ok), 32'd0);
    cyc();
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; a_stall = 1'b0; b_stall = 1'b0;
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    b_drive(1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);   // req held during reset must be ignored
    cyc();
    smp(); chk("b_addr_ok_in_reset", 32'(b_addr_ok), 32'd0);
    cyc();
    a_reset = 1'b0; b_reset = 1'b0;
    b_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp();
    chk("a_rst_data_ok", 32'(a_data_ok), 32'd0);
    chk("a_rst_rdata",   a_rdata,         32'h0);
    chk("a_rst_mis",     32'(a_mis),      32'd0);
    chk("b_rst_data_ok", 32'(b_data_ok), 32'd0);
    chk("b_rst_mis",     32'(b_mis),      32'd0);
    cyc();

    // ---- A: write-then-read back to back ----
    $display("[A] write 0x10 wdata=deadbeef wstrb=f");
    a_drive(1'b1, 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF);
    smp(); chk("a_wr_addr_ok", 32'(a_addr_ok), 32'd1);
    chk("a_wr_no_early_ok", 32'(a_data_ok), 32'd0);
    cyc();
    $display("[A] read 0x10");
    a_drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    smp(); chk("a_rd_addr_ok", 32'(a_addr_ok), 32'd1);
    chk("a_wr_resp_ok", 32'(a_data_ok), 32'd1);
    chk("a_wr_resp_rdata", a_rdata, 32'h0);
    cyc();
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("a_rd_resp_ok", 32'(a_data_ok), 32'd1);
    chk("a_rd_resp_rdata", a_rdata, 32'hDEADBEEF);
    cyc();

    // ---- A: single-byte strobe into lane 1 ----
    $display("[A] write 0x11 wdata=0000aa00 wstrb=2 (byte)");
    a_drive(1'b1, 1'b1, 2'd0, 32'h11, 4'h2, 32'h0000AA00);
    smp(); chk("a_idle_no_ok", 32'(a_data_ok), 32'd0);
    cyc();
    $display("[A] read 0x10");
    a_drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    smp(); chk("a_bwr_resp_ok", 32'(a_data_ok), 32'd1);
    chk("a_bwr_resp_rdata", a_rdata, 32'h0);
    cyc();
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("a_strb_rdata", a_rdata, 32'hDEADAAEF);
    cyc();

    // ---- A: stall_inject holds off acceptance for 3 cycles ----
    $display("[A] read 0x10 with stall_inject for 3 cycles");
    a_drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    a_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("a_stall_addr_ok", 32'(a_addr_ok), 32'd0);
      chk("a_stall_data_ok", 32'(a_data_ok), 32'd0);
      cyc();
    end
    a_stall = 1'b0;
    smp(); chk("a_unstall_addr_ok", 32'(a_addr_ok), 32'd1);
    cyc();
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("a_unstall_data_ok", 32'(a_data_ok), 32'd1);
    chk("a_unstall_rdata", a_rdata, 32'hDEADAAEF);
    cyc();

    // ---- A: aligned half-word must not flag; misaligned word must ----
    $display("[A] read half 0x12 (aligned)");
    a_drive(1'b1, 1'b0, 2'd1, 32'h12, 4'h0, 32'h0);
    smp(); chk("a_half_addr_ok", 32'(a_addr_ok), 32'd1);
    cyc();
    $display("[A] read word 0x12 (misaligned)");
    a_drive(1'b1, 1'b0, 2'd2, 32'h12, 4'h0, 32'h0);
    smp(); chk("a_mis_before", 32'(a_mis), 32'd0);
    chk("a_half_rdata", a_rdata, 32'hDEADAAEF);
    cyc();
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("a_mis_set", 32'(a_mis), 32'd1);
    chk("a_mis_data_ok", 32'(a_data_ok), 32'd1);
    chk("a_mis_rdata", a_rdata, 32'hDEADAAEF);
    cyc();
    smp(); chk("a_mis_sticky", 32'(a_mis), 32'd1);
    cyc();
    $display("[A] reset with req held");
    a_reset = 1'b1;
    a_drive(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    smp(); chk("a_addr_ok_in_reset", 32'(a_addr_ok), 32'd0);
    cyc();
    a_reset = 1'b0;
    a_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("a_mis_cleared", 32'(a_mis), 32'd0);
    chk("a_post_rst_data_ok", 32'(a_data_ok), 32'd0);
    cyc();

    // ---- B: preload words, checking LATENCY=3 response timing ----
    b_write_word(32'h0, 32'h11111111);
    b_write_word(32'h4, 32'h22222222);
    b_write_word(32'h8, 32'h33333333);

    // ---- B: full queue with req held on reads 0x0, 0x4, 0x8 ----
    $display("[B] read 0x0 (T0)");
    b_drive(1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
    smp(); chk("b_full_t0_addr_ok", 32'(b_addr_ok), 32'd1);
    cyc();
    $display("[B] read 0x4 (T1)");
    b_addr = 32'h4;
    smp(); chk("b_full_t1_addr_ok", 32'(b_addr_ok), 32'd1);
    cyc();
    $display("[B] read 0x8 held (T2..T4)");
    b_addr = 32'h8;
    smp(); chk("b_full_t2_addr_ok", 32'(b_addr_ok), 32'd0);
    chk("b_full_t2_data_ok", 32'(b_data_ok), 32'd0);
    cyc();
    smp(); chk("b_full_t3_addr_ok", 32'(b_addr_ok), 32'd0);
    chk("b_full_t3_data_ok", 32'(b_data_ok), 32'd1);
    chk("b_full_t3_rdata", b_rdata, 32'h11111111);
    cyc();
    smp(); chk("b_full_t4_addr_ok", 32'(b_addr_ok), 32'd1);
    chk("b_full_t4_data_ok", 32'(b_data_ok), 32'd1);
    chk("b_full_t4_rdata", b_rdata, 32'h22222222);
    cyc();
    b_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    smp(); chk("b_full_t5_data_ok", 32'(b_data_ok), 32'd0);
    cyc();
    smp(); chk("b_full_t6_data_ok", 32'(b_data_ok), 32'd0);
    cyc();
    smp(); chk("b_full_t7_data_ok", 32'(b_data_ok), 32'd1);
    chk("b_full_t7_rdata", b_rdata, 32'h33333333);
    cyc();
    smp(); chk("b_full_t8_data_ok", 32'(b_data_ok), 32'd0);
    cyc();

    // ---- B: reset while a read is in flight ----
    $display("[B] read 0x0 then reset next cycle");
    b_drive(1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
    smp(); chk("b_rf_addr_ok", 32'(b_addr_ok), 32'd1);
    cyc();
    b_reset = 1'b1;
    smp(); chk("b_rf_addr_ok_rst", 32'(b_addr_ok), 32'd0);
    cyc();
    b_reset = 1'b0;
    b_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      smp(); chk("b_rf_no_data_ok", 32'(b_data_ok), 32'd0);
      cyc();
    end
    $display("[B] read 0x4 after reset (memory retained)");
    b_drive(1'b1, 1'b0, 2'd2, 32'h4, 4'h0, 32'h0);
    smp(); chk("b_post_rst_addr_ok", 32'(b_addr_ok), 32'd1);
    cyc();
    b_drive(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    cyc(); cyc();
    smp(); chk("b_post_rst_data_ok", 32'(b_data_ok), 32'd1);
    chk("b_post_rst_rdata", b_rdata, 32'h22222222);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
